// File: rtl/regfile_write_arbiter.sv
// +--------------------------------------------------------------------------+
// | regfile_write_arbiter: round-robin / debug-lock arbiter for the regfile   |
// | write port with XZR suppression.                         Revision: 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            req_valid,
  input  logic [3*ADDR_W-1:0]   req_add,
  input  logic [3*DATA_W-1:0]   req_data,
  output logic [2:0]            req_ready,
  input  logic                  dbg_lock,
  output logic                  lock_active,
  output logic                  write_en,
  output logic [ADDR_W-1:0]     write_add,
  output logic [DATA_W-1:0]     write_data,
  output logic [31:0]           pending_mask,
  output logic [CNT_W-1:0]      xzr_drop_cnt
);

  localparam int              NUM_REQ = 3;
  localparam logic [ADDR_W-1:0] XZR_ADD = ADDR_W'(31);

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        rr_ptr;
  logic [1:0]        rr_nxt;
  logic [2:0]        grant;
  logic              accept;
  logic              sel_is_xzr;
  logic [ADDR_W-1:0] sel_add;
  logic [DATA_W-1:0] sel_data;
  logic [ADDR_W-1:0] add_arr  [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign add_arr[i]  = req_add[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB;
      rr_ptr <= 2'd0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    grant     = 3'b000;
    case (state)
      ARB: begin
        if (dbg_lock) state_nxt = LOCK;
        // Search starts at rr_ptr and wraps modulo 3
        case (rr_ptr)
          2'd1: begin
            if      (req_valid[1]) grant = 3'b010;
            else if (req_valid[2]) grant = 3'b100;
            else if (req_valid[0]) grant = 3'b001;
          end
          2'd2: begin
            if      (req_valid[2]) grant = 3'b100;
            else if (req_valid[0]) grant = 3'b001;
            else if (req_valid[1]) grant = 3'b010;
          end
          default: begin
            if      (req_valid[0]) grant = 3'b001;
            else if (req_valid[1]) grant = 3'b010;
            else if (req_valid[2]) grant = 3'b100;
          end
        endcase
        if      (grant[0]) rr_nxt = 2'd1;
        else if (grant[1]) rr_nxt = 2'd2;
        else if (grant[2]) rr_nxt = 2'd0;
      end
      LOCK: begin
        if (!dbg_lock) state_nxt = ARB;
        grant[2] = req_valid[2];
      end
      default: state_nxt = ARB;
    endcase
    if (!rst_n) grant = 3'b000;
  end

  assign req_ready   = grant;
  assign lock_active = (state == LOCK);
  assign accept      = |grant;

  always_comb begin
    sel_add  = add_arr[0];
    sel_data = data_arr[0];
    case (grant)
      3'b010: begin
        sel_add  = add_arr[1];
        sel_data = data_arr[1];
      end
      3'b100: begin
        sel_add  = add_arr[2];
        sel_data = data_arr[2];
      end
      default: begin
        sel_add  = add_arr[0];
        sel_data = data_arr[0];
      end
    endcase
  end

  assign sel_is_xzr = (sel_add == XZR_ADD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en   <= 1'b0;
      write_add  <= '0;
      write_data <= '0;
    end else begin
      write_en <= accept && !sel_is_xzr;
      if (accept && !sel_is_xzr) begin
        write_add  <= sel_add;
        write_data <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xzr_drop_cnt <= '0;
    end else if (accept && sel_is_xzr && (xzr_drop_cnt != {CNT_W{1'b1}})) begin
      xzr_drop_cnt <= xzr_drop_cnt + 1'b1;
    end
  end

  for (genvar r = 0; r < 32; r++) begin : g_pending
    if (r == 31) begin : g_xzr
      assign pending_mask[r] = 1'b0;
    end else begin : g_reg
      localparam logic [ADDR_W-1:0] REG_ADD = ADDR_W'(r);
      assign pending_mask[r] = (req_valid[0] && (add_arr[0] == REG_ADD)) ||
                               (req_valid[1] && (add_arr[1] == REG_ADD)) ||
                               (req_valid[2] && (add_arr[2] == REG_ADD)) ||
                               (write_en && (write_add == REG_ADD));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; a CNT_W=2 copy shares the stimulus
// to exercise counter saturation.
`default_nettype none

module tb_regfile_write_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   req_valid;
  logic [14:0]  req_add;
  logic [191:0] req_data;
  logic         dbg_lock;

  logic [2:0]   req_ready;
  logic         lock_active;
  logic         write_en;
  logic [4:0]   write_add;
  logic [63:0]  write_data;
  logic [31:0]  pending_mask;
  logic [15:0]  xzr_drop_cnt;

  logic [2:0]   sat_ready;
  logic         sat_lock;
  logic         sat_en;
  logic [4:0]   sat_add;
  logic [63:0]  sat_data;
  logic [31:0]  sat_pending;
  logic [1:0]   sat_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_add(req_add),
    .req_data(req_data), .req_ready(req_ready), .dbg_lock(dbg_lock),
    .lock_active(lock_active), .write_en(write_en), .write_add(write_add),
    .write_data(write_data), .pending_mask(pending_mask),
    .xzr_drop_cnt(xzr_drop_cnt)
  );

  regfile_write_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_add(req_add),
    .req_data(req_data), .req_ready(sat_ready), .dbg_lock(dbg_lock),
    .lock_active(sat_lock), .write_en(sat_en), .write_add(sat_add),
    .write_data(sat_data), .pending_mask(sat_pending),
    .xzr_drop_cnt(sat_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [63:0] d);
    req_valid[i]       = 1'b1;
    req_add[i*5 +: 5]  = a;
    req_data[i*64 +: 64] = d;
  endtask

  task automatic do_reset();
    req_valid = 3'b000;
    dbg_lock  = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    req_valid = 3'b000;
    req_add   = '0;
    req_data  = '0;
    dbg_lock  = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Reset state
    check_val("rst_write_en",   64'(write_en),     64'd0);
    check_val("rst_write_add",  64'(write_add),    64'd0);
    check_val("rst_write_data", write_data,        64'd0);
    check_val("rst_cnt",        64'(xzr_drop_cnt), 64'd0);
    check_val("rst_lock",       64'(lock_active),  64'd0);
    check_val("rst_ready",      64'(req_ready),    64'd0);
    check_val("rst_pending",    64'(pending_mask), 64'd0);

    // Single request
    set_req(0, 5'd5, 64'h1234);
    #1;
    check_val("single_ready",   64'(req_ready),    64'b001);
    check_val("single_pending", 64'(pending_mask), 64'h20);
    tick();
    check_val("single_en",   64'(write_en),  64'd1);
    check_val("single_add",  64'(write_add), 64'd5);
    check_val("single_data", write_data,     64'h1234);
    req_valid = 3'b000;
    tick();
    check_val("single_en_off", 64'(write_en), 64'd0);

    // Round-robin with all three valid
    do_reset();
    set_req(0, 5'd1, 64'h10);
    set_req(1, 5'd2, 64'h11);
    set_req(2, 5'd3, 64'h12);
    #1;
    check_val("rr_pending", 64'(pending_mask), 64'hE);
    for (int k = 0; k < 4; k++) begin
      check_val("rr_ready", 64'(req_ready), 64'(3'b001 << (k % 3)));
      tick();
      check_val("rr_en",   64'(write_en),  64'd1);
      check_val("rr_add",  64'(write_add), 64'((k % 3) + 1));
      check_val("rr_data", write_data,     64'(32'h10 + (k % 3)));
    end
    req_valid = 3'b000;
    tick();
    check_val("rr_en_off", 64'(write_en), 64'd0);

    // XZR suppression and saturation
    do_reset();
    set_req(1, 5'd31, 64'hFFFF);
    #1;
    check_val("xzr_ready",   64'(req_ready),    64'b010);
    check_val("xzr_pending", 64'(pending_mask), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("xzr_en", 64'(write_en), 64'd0);
    end
    check_val("xzr_cnt3",     64'(xzr_drop_cnt), 64'd3);
    check_val("xzr_sat_cnt3", 64'(sat_cnt),      64'd3);
    tick();
    tick();
    check_val("xzr_cnt5",    64'(xzr_drop_cnt), 64'd5);
    check_val("xzr_sat_hold", 64'(sat_cnt),      64'd3);
    req_valid = 3'b000;
    tick();

    // Debug lock
    do_reset();
    set_req(0, 5'd4, 64'h40);
    set_req(2, 5'd9, 64'h90);
    dbg_lock = 1'b1;
    #1;
    check_val("lock_rise_state", 64'(lock_active), 64'd0);
    check_val("lock_rise_ready", 64'(req_ready),   64'b001);
    tick();
    check_val("lock_active",    64'(lock_active), 64'd1);
    check_val("lock_prev_add",  64'(write_add),   64'd4);
    check_val("lock_ready",     64'(req_ready),   64'b100);
    tick();
    check_val("lock_en",    64'(write_en),  64'd1);
    check_val("lock_add",   64'(write_add), 64'd9);
    check_val("lock_data",  write_data,     64'h90);
    check_val("lock_ready2", 64'(req_ready), 64'b100);
    dbg_lock     = 1'b0;
    req_valid[2] = 1'b0;
    #1;
    check_val("lock_fall_state", 64'(lock_active), 64'd1);
    check_val("lock_fall_ready", 64'(req_ready),   64'b000);
    tick();
    check_val("unlock_state", 64'(lock_active), 64'd0);
    check_val("unlock_ready", 64'(req_ready),   64'b001);
    check_val("unlock_en",    64'(write_en),    64'd0);
    tick();

    // Same-address conflict with rr_ptr = 1
    set_req(0, 5'd7, 64'hA);
    set_req(1, 5'd7, 64'hB);
    #1;
    check_val("conf_ready1",  64'(req_ready),    64'b010);
    check_val("conf_pending", 64'(pending_mask), 64'h90);
    tick();
    check_val("conf_en1",   64'(write_en),  64'd1);
    check_val("conf_add1",  64'(write_add), 64'd7);
    check_val("conf_data1", write_data,     64'hB);
    req_valid[1] = 1'b0;
    #1;
    check_val("conf_ready2",   64'(req_ready),    64'b001);
    check_val("conf_pending2", 64'(pending_mask), 64'h80);
    tick();
    check_val("conf_data2", write_data, 64'hA);
    req_valid = 3'b000;
    #1;
    check_val("conf_pending3", 64'(pending_mask), 64'h80);
    tick();
    check_val("conf_en_off",   64'(write_en),     64'd0);
    check_val("conf_pending0", 64'(pending_mask), 64'd0);

    // Reset during an active write
    set_req(1, 5'd31, 64'h1);
    #1;
    check_val("mid_xzr_ready", 64'(req_ready), 64'b010);
    tick();
    check_val("mid_cnt1", 64'(xzr_drop_cnt), 64'd1);
    req_valid = 3'b000;
    set_req(2, 5'd12, 64'hC);
    #1;
    check_val("mid_ready", 64'(req_ready), 64'b100);
    tick();
    check_val("mid_en", 64'(write_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_en",    64'(write_en),     64'd0);
    check_val("mid_rst_add",   64'(write_add),    64'd0);
    check_val("mid_rst_cnt",   64'(xzr_drop_cnt), 64'd0);
    check_val("mid_rst_lock",  64'(lock_active),  64'd0);
    check_val("mid_rst_ready", 64'(req_ready),    64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_val("post_rst_ready", 64'(req_ready), 64'b100);
    tick();
    check_val("post_rst_en",   64'(write_en),  64'd1);
    check_val("post_rst_add",  64'(write_add), 64'd12);
    check_val("post_rst_data", write_data,     64'hC);
    req_valid = 3'b000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32 x 64-bit register file between three writeback requesters: ALU result (0), load data (1), and a debug/initialisation loader (2). Each requester uses a valid/ready handshake. Requesters are granted round-robin, or the debug port takes exclusive ownership while locked. Writes to XZR (X31) are acknowledged but never reach the register file. The block registers the winning request onto the register file's write_en / write_add / write_data inputs.

## Interface
- DATA_W, 64, write data width
- ADDR_W, 5, register address width (32 registers; address 31 = XZR)
- CNT_W, 16, width of the suppressed-write counter
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  3  per-requester request valid; bit i = requester i
- req_add  in  3*ADDR_W  destination register; slice [i*ADDR_W +: ADDR_W]
- req_data  in  3*DATA_W  write data; slice [i*DATA_W +: DATA_W]
- req_ready  out  3  one-hot grant; accept = req_valid[i] & req_ready[i]
- dbg_lock  in  1  debug requests exclusive ownership of the write port
- lock_active  out  1  high while the FSM is in LOCK
- write_en  out  1  register-file write enable
- write_add  out  ADDR_W  register-file write address
- write_data  out  DATA_W  register-file write data
- pending_mask  out  32  registers with an outstanding or in-flight write
- xzr_drop_cnt  out  CNT_W  saturating count of accepted writes to X31

## Operation
- FSM states:
  - ARB: reset state; round-robin over requesters 0..2.
  - LOCK: only requester 2 is eligible; req_ready[1:0] = 0.
- FSM transitions:
  - ARB -> LOCK on a clock edge where dbg_lock = 1.
  - LOCK -> ARB on a clock edge where dbg_lock = 0.
  - dbg_lock is sampled, not combinational: the cycle in which dbg_lock rises is still arbitrated as ARB.
- Round-robin pointer rr_ptr is in {0,1,2}; reset value 0.
  - Search order is rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - The first requester with valid set is granted.
  - After a grant in ARB, rr_ptr = (granted+1) mod 3.
  - rr_ptr holds when nothing is granted and throughout LOCK.
- In LOCK: req_ready[2] = req_valid[2]; the other ready bits are 0.
- req_ready is combinational from req_valid, the FSM state and rr_ptr. At most one bit is high, and never without the matching valid.
- No backpressure exists downstream: every grant is accepted the same cycle.
- Accepted request with address != 31:
  - next cycle: write_en = 1, write_add = req_add, write_data = req_data.
- Accepted request with address == 31:
  - next cycle: write_en = 0.
  - xzr_drop_cnt increments by 1 and saturates at 2^CNT_W - 1 (no wrap).
- Two requesters targeting the same register in the same cycle: the round-robin winner writes first and the loser waits. Both writes reach the register file in grant order.
- pending_mask (combinational): bit r is set if either:
  - any req_valid[i] has req_add = r, or
  - write_en = 1 and write_add = r.
  - Bit 31 is always 0.
- Requesters must hold valid, address and data stable until accepted. Dropping valid before acceptance is allowed and produces no write.

## Timing
- Grant latency: 0 cycles; ready is asserted in the same cycle valid is presented, if that requester wins.
- Write latency: the accept in cycle t drives the register-file write in cycle t+1, for exactly one cycle.
- Throughput: one write per cycle. Back-to-back grants give back-to-back write_en.
- Reset values (asynchronous, immediate on rst_n = 0):
  - write_en 0, write_add 0, write_data 0
  - xzr_drop_cnt 0, lock_active 0, state ARB, rr_ptr 0
- Reset mid-operation: an in-flight write is discarded (write_en falls immediately). req_ready is 0 while rst_n = 0.
- On the first edge after reset release, arbitration resumes from rr_ptr = 0.

## Test plan
- Single request: req 0 valid, add 5, data 0x1234 in cycle t -> req_ready = 001 in t. In t+1: write_en = 1, write_add = 5, write_data = 0x1234. In t+2: write_en = 0.
- Round-robin: all three valid continuously with distinct adds 1, 2, 3 -> grants 0, 1, 2, 0 ... on consecutive cycles. write_en stays high every cycle after the first.
- XZR suppression: req 1 writes add 31, data 0xFFFF, three times -> write_en stays 0 and xzr_drop_cnt = 3. With CNT_W = 2 and five such writes -> count saturates at 3.
- Lock: dbg_lock = 1 with req 0 and req 2 valid -> after one edge, lock_active = 1 and only req 2 is granted; req 0 is held. When dbg_lock = 0 -> return to ARB on the next edge and req 0 is granted.
- Same-address conflict: req 0 and req 1 both target add 7 with data 0xA and 0xB, rr_ptr = 1 -> 0xB is written first, then 0xA. pending_mask[7] is high until the second write_en cycle ends.
- Reset mid-write: rst_n pulsed low during a write_en = 1 cycle -> write_en drops immediately, counter = 0, state ARB. After release, req 2 alone is granted on the first cycle.
